// File: rtl/cond_logic.sv
// cond_logic -- condition stage of the multicycle ARM core.
// Holds the NZCV flag register and evaluates the instruction condition field
// once per instruction, in the decode cycle that follows the IRWrite fetch cycle.
// Uses the latched condition result to gate the decoder's PCS/RegW/MemW/FlagW
// requests into the architectural write enables.
// Optional feature: define COND_PERF_CNT_EN to add saturating ExecCount/SkipCount
// counters of passing and failing decode cycles.
module cond_logic #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             NextPC,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic             CondEx
`ifdef COND_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
`endif
);

  // ARM condition field encodings.
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Flag register bit positions within {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;
  logic n_eq_v;
  logic cond_pass;
  logic dec_q;
  logic write_nz;
  logic write_cv;

  assign flag_n = Flags[FLAG_N];
  assign flag_z = Flags[FLAG_Z];
  assign flag_c = Flags[FLAG_C];
  assign flag_v = Flags[FLAG_V];
  assign n_eq_v = (flag_n == flag_v);

  // Evaluate the condition field against the registered (pre-update) flags.
  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      COND_EQ: cond_pass = flag_z;
      COND_NE: cond_pass = ~flag_z;
      COND_CS: cond_pass = flag_c;
      COND_CC: cond_pass = ~flag_c;
      COND_MI: cond_pass = flag_n;
      COND_PL: cond_pass = ~flag_n;
      COND_VS: cond_pass = flag_v;
      COND_VC: cond_pass = ~flag_v;
      COND_HI: cond_pass = flag_c & ~flag_z;
      COND_LS: cond_pass = ~flag_c | flag_z;
      COND_GE: cond_pass = n_eq_v;
      COND_LT: cond_pass = ~n_eq_v;
      COND_GT: cond_pass = ~flag_z & n_eq_v;
      COND_LE: cond_pass = flag_z | ~n_eq_v;
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0; // NV never executes
    endcase
  end

  // Flag-group writes only land when the current instruction passed its condition.
  assign write_nz = FlagW[1] & CondEx;
  assign write_cv = FlagW[0] & CondEx;

  // Mark the decode cycle: one cycle after each IRWrite fetch cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what lets decode see the old Flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_q <= 1'b0;
    end else begin
      dec_q <= IRWrite;
    end
  end

  // Latch the condition result in each decode cycle; hold it for the rest of the instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CondEx <= 1'b0;
    end else if (dec_q) begin
      CondEx <= cond_pass;
    end
  end

  // Update the N,Z and C,V flag pairs independently under their write enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags <= 4'b0000;
    end else begin
      if (write_nz) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (write_cv) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Architectural write enables, combinational from the registered condition result.
  assign PCWrite  = (PCS & CondEx) | NextPC;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;

`ifdef COND_PERF_CNT_EN
  // Count passing and failing decode cycles; each counter sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ExecCount <= '0;
      SkipCount <= '0;
    end else if (dec_q) begin
      if (cond_pass) begin
        if (ExecCount != '1) ExecCount <= ExecCount + CNT_W'(1);
      end else begin
        if (SkipCount != '1) SkipCount <= SkipCount + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic -- directed self-checking bench for cond_logic.
// Builds with or without COND_PERF_CNT_EN; the counter section runs only when defined.
module tb_cond_logic;

  localparam int CNT_W = 2;

  logic       clk;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;
`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] ExecCount;
  logic [CNT_W-1:0] SkipCount;
`endif

  int checks   = 0;
  int failures = 0;

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .NextPC   (NextPC),
    .RegW     (RegW),
    .MemW     (MemW),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags),
    .CondEx   (CondEx)
`ifdef COND_PERF_CNT_EN
    ,
    .ExecCount(ExecCount),
    .SkipCount(SkipCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch cycle (IRWrite=1) then decode cycle; CondEx is updated after return.
  task automatic run_decode(input logic [3:0] c);
    Cond    = c;
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    step();
  endtask

  // Load the flag register: execute an AL instruction that writes both flag groups.
  task automatic load_flags(input logic [3:0] f);
    run_decode(4'b1110);
    FlagW    = 2'b11;
    ALUFlags = f;
    step();
    FlagW    = 2'b00;
  endtask

  // Reference condition table, written as base condition plus inversion by Cond[0].
  function automatic logic model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  initial begin
    reset    = 1'b0;
    Cond     = 4'b0000;
    ALUFlags = 4'b0000;
    FlagW    = 2'b00;
    PCS      = 1'b0;
    NextPC   = 1'b1;
    RegW     = 1'b1;
    MemW     = 1'b1;
    IRWrite  = 1'b0;
    #3;

    // Reset state: gated writes low, PC increment passes through.
    check("rst_pcwrite",  32'(PCWrite),  32'd1);
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_flags",    32'(Flags),    32'h0);
    check("rst_condex",   32'(CondEx),   32'd0);
    step();
    reset  = 1'b1;
    NextPC = 1'b0;
    RegW   = 1'b0;
    MemW   = 1'b0;

    // AL then flag write of 0100, then BEQ taken.
    run_decode(4'b1110);
    check("al_condex", 32'(CondEx), 32'd1);
    FlagW    = 2'b11;
    ALUFlags = 4'b0100;
    step();
    FlagW    = 2'b00;
    check("al_flags", 32'(Flags), 32'h4);
    run_decode(4'b0000);
    PCS = 1'b1;
    #1;
    check("beq_condex",  32'(CondEx),  32'd1);
    check("beq_pcwrite", 32'(PCWrite), 32'd1);
    PCS = 1'b0;

    // BNE not taken: all gated writes blocked, flags untouched.
    run_decode(4'b0001);
    PCS      = 1'b1;
    RegW     = 1'b1;
    FlagW    = 2'b11;
    ALUFlags = 4'b1011;
    #1;
    check("bne_condex",   32'(CondEx),   32'd0);
    check("bne_pcwrite",  32'(PCWrite),  32'd0);
    check("bne_regwrite", 32'(RegWrite), 32'd0);
    step();
    check("bne_flags", 32'(Flags), 32'h4);
    PCS   = 1'b0;
    RegW  = 1'b0;
    FlagW = 2'b00;

    // C,V-only write preserves N,Z.
    load_flags(4'b1100);
    check("pre_cv_flags", 32'(Flags), 32'hC);
    FlagW    = 2'b01;
    ALUFlags = 4'b0011;
    step();
    FlagW    = 2'b00;
    check("cv_only_flags", 32'(Flags), 32'hF);

    // N,Z-only write preserves C,V.
    FlagW    = 2'b10;
    ALUFlags = 4'b0000;
    step();
    FlagW    = 2'b00;
    check("nz_only_flags", 32'(Flags), 32'h3);

    // Flag write coinciding with decode: evaluation sees old flags, write still lands.
    load_flags(4'b0100);
    Cond     = 4'b0000;
    IRWrite  = 1'b1;
    step();
    IRWrite  = 1'b0;
    FlagW    = 2'b11;
    ALUFlags = 4'b0000;
    step();
    FlagW    = 2'b00;
    check("overlap_condex", 32'(CondEx), 32'd1);
    check("overlap_flags",  32'(Flags),  32'h0);

    // Back-to-back IRWrite: each following cycle re-evaluates.
    Cond    = 4'b1110;
    IRWrite = 1'b1;
    step();
    step();
    check("b2b_first_condex", 32'(CondEx), 32'd1);
    Cond    = 4'b1111;
    IRWrite = 1'b0;
    step();
    check("b2b_second_condex", 32'(CondEx), 32'd0);

    // Full condition sweep over every flag value.
    for (int f = 0; f < 16; f++) begin
      load_flags(4'(f));
      check($sformatf("sweep_flags_%0h", f), 32'(Flags), 32'(f));
      for (int c = 0; c < 16; c++) begin
        run_decode(4'(c));
        check($sformatf("sweep_c%0h_f%0h", c, f), 32'(CondEx), 32'(model(4'(c), 4'(f))));
      end
    end

    // Asynchronous reset mid-instruction clears state without a clock edge.
    load_flags(4'b1010);
    RegW = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_condex",   32'(CondEx),   32'd0);
    check("midrst_flags",    32'(Flags),    32'h0);
    check("midrst_regwrite", 32'(RegWrite), 32'd0);
    reset = 1'b1;
    Cond    = 4'b1110;
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    check("postrst_fetch_condex", 32'(CondEx),   32'd0);
    check("postrst_fetch_regw",   32'(RegWrite), 32'd0);
    step();
    check("postrst_dec_condex", 32'(CondEx),   32'd1);
    check("postrst_dec_regw",   32'(RegWrite), 32'd1);
    RegW = 1'b0;

`ifdef COND_PERF_CNT_EN
    // Saturating perf counters, starting from a clean reset.
    #2;
    reset = 1'b0;
    #1;
    check("cnt_rst_exec", 32'(ExecCount), 32'd0);
    check("cnt_rst_skip", 32'(SkipCount), 32'd0);
    reset = 1'b1;
    step();
    for (int i = 0; i < 3; i++) run_decode(4'b1110);
    for (int i = 0; i < 2; i++) run_decode(4'b1111);
    check("cnt_exec_3", 32'(ExecCount), 32'd3);
    check("cnt_skip_2", 32'(SkipCount), 32'd2);
    for (int i = 0; i < 2; i++) run_decode(4'b1110);
    check("cnt_exec_sat", 32'(ExecCount), 32'd3);
    check("cnt_skip_hold", 32'(SkipCount), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
